// File: rtl/ram4_16.sv
// Four-word memory bank: a 4-way demux steers the write enable to one word
// register, and a 4-way word mux returns the addressed word combinationally.

module dmux_4way_gate (
  input  logic       in,
  input  logic [1:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d
);

  assign a = in & ~sel[1] & ~sel[0];
  assign b = in & ~sel[1] &  sel[0];
  assign c = in &  sel[1] & ~sel[0];
  assign d = in &  sel[1] &  sel[0];

endmodule

module ram4_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [1:0]       address,
  output logic [WIDTH-1:0] out
);

  logic [3:0]       word_load;
  logic [WIDTH-1:0] word_q [4];
  logic [WIDTH-1:0] word_d [4];

  dmux_4way_gate u_load_dmux (
    .in  (load),
    .sel (address),
    .a   (word_load[0]),
    .b   (word_load[1]),
    .c   (word_load[2]),
    .d   (word_load[3])
  );

  // Each bit is a load register: take new data when its word is selected, else hold.
  always_comb begin
    for (int w = 0; w < 4; w++) begin
      word_d[w] = word_q[w];
      for (int b = 0; b < WIDTH; b++) begin
        word_d[w][b] = word_load[w] ? in[b] : word_q[w][b];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < 4; w++) begin
        word_q[w] <= '0;
      end
    end else begin
      for (int w = 0; w < 4; w++) begin
        word_q[w] <= word_d[w];
      end
    end
  end

  // Read has no bypass: a same-address write only shows after the edge.
  always_comb begin
    out = word_q[address];
  end

endmodule

// File: doc/ram4_16.md
# ram4_16

Four-word, 16-bit memory bank built on `dmux_4way_gate`. The write-enable `load` is routed by one `dmux_4way_gate` instance to exactly one of four word registers, selected by `address`. A 4-way word multiplexer returns the addressed word on `out`. It is the first addressable memory stage above the Week 1 gates and the building block for `ram8`/`ram64`.

## Interface
- `WIDTH`, default 16: word width in bits; all data ports and registers use this width.
- `clk`: input, 1 bit. Single clock; all storage updates on the rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high; clears all four words.
- `in`: input, WIDTH bits. Write data.
- `load`: input, 1 bit. Write enable for the addressed word.
- `address`: input, 2 bits. Word select for both write and read.
- `out`: output, WIDTH bits. Contents of the word at `address`.

## Operation
- Storage consists of four WIDTH-bit registers, `word0`..`word3`. Each register is built from WIDTH 1-bit load registers (bit = DFF + load mux).
- Load decode:
  - One `dmux_4way_gate` instance has `in=load` and `sel=address`.
  - Its outputs `a`, `b`, `c`, `d` drive the loads of `word0`, `word1`, `word2`, `word3` respectively.
  - At most one word's load is asserted in any cycle.
- Write: at a rising `clk` edge with `load=1` and `reset=0`, `word[address] <= in`. The other three words hold.
- Hold: at a rising edge with `load=0`, all words hold.
- Read:
  - `out = word[address]`, combinational from the current register contents and `address`.
  - There is no read latency in address. A change of `address` changes `out` in the same cycle.
- Read-during-write to the same address:
  - `out` shows the old contents until the edge.
  - After the edge, `out` shows `in` as sampled at that edge.
  - There is no write-through bypass.
- Reset:
  - `reset=1` forces all four words to 0 immediately, independent of `clk`.
  - Therefore `out=0` for every address while reset is held.
- Reset beats load: a rising edge with `reset=1` and `load=1` stores nothing. Words stay 0.
- Reset mid-operation: asserting `reset` between edges clears all data at once. The first write after deassertion behaves as a normal write.
- There is no wrap-around or overflow behaviour. Every 2-bit address is valid.

## Timing
- Write latency is 1 cycle. Data presented with `load=1` before edge N is visible on `out` after edge N, with `address` unchanged.
- `in`, `load` and `address` must be stable around each rising `clk` edge (setup/hold). They are sampled only at the edge.
- `out` settles combinationally after `address` changes, or after the clock edge that updates the addressed word.
- `reset` deassertion must not coincide with a rising `clk` edge carrying `load=1`. The result of that case is not defined.
- Reset value of `out` is 16'h0000.

## Test plan
- Reset clears:
  - Write 16'hFFFF to all 4 addresses, then pulse `reset` high mid-cycle.
  - Required: `out=16'h0000` immediately for addresses 0..3, both during and after reset.
- Independent writes:
  - Write 16'h1111, 16'h2222, 16'h3333, 16'h4444 to addresses 0..3 on successive edges.
  - Required: reading 0..3 returns exactly those values.
- Load gating:
  - With address 2 holding 16'h3333, apply `in=16'hBEEF`, `load=0`, `address=2` for 3 edges.
  - Required: `out=16'h3333` throughout.
- Write latency:
  - Set `address=1`, `in=16'hA5A5`, `load=1` before an edge. Address 1 currently holds 16'h2222.
  - Required: `out=16'h2222` before the edge and `16'hA5A5` after it. Addresses 0, 2 and 3 are unchanged.
- Reset priority:
  - Hold `reset=1` with `load=1`, `in=16'hCAFE`, `address=3` across 2 edges, then deassert.
  - Required: reading address 3 returns 16'h0000.
- Address sweep:
  - With no writes, change `address` 0→3→1→2 without any clock edges.
  - Required: `out` tracks each stored word combinationally.
